// File: rtl/thor2024_pc_redirect_arb_pkg.sv
// Shared types for the PC redirect arbiter: PC address type, redirect source
// encoding and the registered redirect record.
package thor2024_pc_redirect_arb_pkg;

  localparam int PC_W = 32;

  typedef logic [PC_W-1:0] pc_address_t;

  typedef enum logic [1:0] {
    RS_MISS = 2'd0,
    RS_EXC  = 2'd1,
    RS_IRQ  = 2'd2,
    RS_BB   = 2'd3
  } redir_src_t;

  typedef struct packed {
    logic        v;
    pc_address_t pc;
    redir_src_t  src;
  } redirect_t;

endpackage

// File: rtl/thor2024_redir_slot.sv
// One-entry redirect holding slot: a new request wins over a restore, and a
// restore wins over a clear (issue or cancel).
module thor2024_redir_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req,
  input  logic [W-1:0] req_pc,
  input  logic         can_take,
  input  logic         restore,
  input  logic [W-1:0] restore_pc,
  input  logic         clear,
  output logic         ack,
  output logic         v,
  output logic [W-1:0] pc
);

  always_comb ack = req & can_take & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v  <= 1'b0;
      pc <= '0;
    end else if (ack) begin
      v  <= 1'b1;
      pc <= req_pc;
    end else if (restore) begin
      v  <= 1'b1;
      pc <= restore_pc;
    end else if (clear) begin
      v  <= 1'b0;
    end
  end

endmodule

// File: rtl/thor2024_pc_redirect_arb.sv
// Arbitrates miss/exception/interrupt/backward-branch redirects into one
// registered valid/ready redirect stream for the fetch PC register.
module thor2024_pc_redirect_arb #(
  parameter int PCW  = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            miss_req,
  input  logic [PCW-1:0]  miss_pc,
  input  logic            exc_req,
  input  logic [PCW-1:0]  exc_pc,
  input  logic            irq_req,
  input  logic [PCW-1:0]  irq_pc,
  input  logic            irq_en,
  input  logic            micro_active,
  input  logic            bb_req,
  input  logic [PCW-1:0]  bb_pc,
  output logic            bb_ack,
  output logic            exc_ack,
  output logic            irq_ack,
  output logic            redir_v,
  output logic [PCW-1:0]  redir_pc,
  output logic [1:0]      redir_src,
  input  logic            redir_rdy,
  output logic            busy,
  output logic [CNTW-1:0] cancel_cnt
);

  import thor2024_pc_redirect_arb_pkg::*;

  logic           miss_v, exc_v, bb_v, miss_ack_unused;
  logic [PCW-1:0] miss_q, exc_q, bb_q;
  redirect_t      out_q, out_d;
  logic           cancel, held, out_cancel, replace, out_free, restore, irq_elig;
  logic           sel_miss, sel_exc, sel_irq, sel_bb;
  logic           exc_can_take, bb_can_take;
  logic [1:0]     cnt_inc;
  logic [CNTW:0]  cnt_sum;
  logic [CNTW-1:0] cnt_q;

  always_comb begin
    cancel     = miss_req | exc_req;
    irq_elig   = irq_req & irq_en & ~micro_active;
    held       = out_q.v & ~redir_rdy;
    out_cancel = held & (out_q.src == RS_BB) & cancel;
    // A presented exc can only be displaced if its slot is free to take it back.
    replace    = held & miss_v & (out_q.src != RS_MISS) &
                 ((out_q.src != RS_EXC) | ~exc_v);
    restore    = replace & (out_q.src == RS_EXC);
    out_free   = ~held | out_cancel | replace;

    sel_miss = out_free & miss_v;
    sel_exc  = out_free & ~miss_v & exc_v;
    sel_irq  = out_free & ~miss_v & ~exc_v & irq_elig;
    sel_bb   = out_free & ~miss_v & ~exc_v & ~irq_elig & bb_v & ~cancel;

    exc_can_take = (~exc_v & ~restore) | sel_exc;
    bb_can_take  = ~miss_req & (~bb_v | sel_bb | exc_req);

    out_d = out_q;
    if (out_free) begin
      out_d.v = sel_miss | sel_exc | sel_irq | sel_bb;
      if (sel_miss) begin
        out_d.pc  = miss_q;
        out_d.src = RS_MISS;
      end else if (sel_exc) begin
        out_d.pc  = exc_q;
        out_d.src = RS_EXC;
      end else if (sel_irq) begin
        out_d.pc  = irq_pc;
        out_d.src = RS_IRQ;
      end else if (sel_bb) begin
        out_d.pc  = bb_q;
        out_d.src = RS_BB;
      end
    end

    cnt_inc = 2'(bb_v & cancel) + 2'(out_cancel);
    cnt_sum = {1'b0, cnt_q} + (CNTW+1)'(cnt_inc);
  end

  thor2024_redir_slot #(.W(PCW)) u_miss_slot (
    .clk(clk), .rst(rst), .req(miss_req), .req_pc(miss_pc), .can_take(1'b1),
    .restore(1'b0), .restore_pc('0), .clear(sel_miss),
    .ack(miss_ack_unused), .v(miss_v), .pc(miss_q)
  );

  thor2024_redir_slot #(.W(PCW)) u_exc_slot (
    .clk(clk), .rst(rst), .req(exc_req), .req_pc(exc_pc), .can_take(exc_can_take),
    .restore(restore), .restore_pc(out_q.pc), .clear(sel_exc),
    .ack(exc_ack), .v(exc_v), .pc(exc_q)
  );

  thor2024_redir_slot #(.W(PCW)) u_bb_slot (
    .clk(clk), .rst(rst), .req(bb_req), .req_pc(bb_pc), .can_take(bb_can_take),
    .restore(1'b0), .restore_pc('0), .clear(sel_bb | cancel),
    .ack(bb_ack), .v(bb_v), .pc(bb_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      cnt_q <= '0;
    end else begin
      out_q <= out_d;
      if (cnt_sum[CNTW]) cnt_q <= '1;
      else               cnt_q <= cnt_sum[CNTW-1:0];
    end
  end

  always_comb begin
    redir_v    = out_q.v;
    redir_pc   = out_q.pc;
    redir_src  = out_q.src;
    irq_ack    = out_q.v & redir_rdy & (out_q.src == RS_IRQ);
    busy       = miss_v | exc_v | bb_v | out_q.v;
    cancel_cnt = cnt_q;
  end

endmodule

// File: tb/tb_thor2024_pc_redirect_arb.sv
// Bench for thor2024_pc_redirect_arb: directed scenarios plus randomized traffic
// checked against a per-cycle behavioural reference model.
module tb_thor2024_pc_redirect_arb;

  localparam int PCW     = 32;
  localparam int CNTW    = 4;
  localparam int CNT_MAX = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic            miss_req, exc_req, irq_req, irq_en, micro_active, bb_req, redir_rdy;
  logic [PCW-1:0]  miss_pc, exc_pc, irq_pc, bb_pc;
  logic            bb_ack, exc_ack, irq_ack, redir_v, busy;
  logic [PCW-1:0]  redir_pc;
  logic [1:0]      redir_src;
  logic [CNTW-1:0] cancel_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  thor2024_pc_redirect_arb #(.PCW(PCW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .miss_req(miss_req), .miss_pc(miss_pc),
    .exc_req(exc_req), .exc_pc(exc_pc),
    .irq_req(irq_req), .irq_pc(irq_pc), .irq_en(irq_en), .micro_active(micro_active),
    .bb_req(bb_req), .bb_pc(bb_pc),
    .bb_ack(bb_ack), .exc_ack(exc_ack), .irq_ack(irq_ack),
    .redir_v(redir_v), .redir_pc(redir_pc), .redir_src(redir_src),
    .redir_rdy(redir_rdy), .busy(busy), .cancel_cnt(cancel_cnt)
  );

  // Reference model: pending requests per source (index = source code, 2 unused)
  bit          mv[4];
  logic [31:0] mpc[4];
  bit          ov;
  logic [31:0] opc;
  int          osrc;
  int          mcnt;
  bit          nv[4];
  logic [31:0] npc[4];
  bit          nov;
  logic [31:0] nopc;
  int          nosrc;
  int          ncnt;
  bit          e_exc_ack, e_bb_ack, e_irq_ack;

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin mv[s] = 0; mpc[s] = '0; end
    ov = 0; opc = '0; osrc = 0; mcnt = 0;
  endtask

  task automatic model_comb();
    bit cancelling, stalled, kill_out, preempt, may_load, elig;
    int pick, inc;
    cancelling = miss_req || exc_req;
    stalled    = ov && !redir_rdy;
    kill_out   = stalled && osrc == 3 && cancelling;
    preempt    = stalled && mv[0] && osrc != 0 && !(osrc == 1 && mv[1]);
    may_load   = !stalled || kill_out || preempt;
    pick = -1;
    if (may_load)
      for (int s = 0; s < 4; s++) begin
        case (s)
          0:       elig = mv[0];
          1:       elig = mv[1];
          2:       elig = irq_req && irq_en && !micro_active;
          default: elig = mv[3] && !cancelling;
        endcase
        if (elig && pick < 0) pick = s;
      end
    e_irq_ack = ov && redir_rdy && osrc == 2;
    e_exc_ack = !rst && exc_req && (pick == 1 || (!mv[1] && !(preempt && osrc == 1)));
    e_bb_ack  = !rst && bb_req && !miss_req && (!mv[3] || pick == 3 || exc_req);
    nv = mv; npc = mpc; inc = 0;
    if (pick >= 0 && pick != 2) nv[pick] = 0;
    if (preempt && osrc == 1) begin nv[1] = 1; npc[1] = opc; end
    if (cancelling && mv[3]) begin nv[3] = 0; inc++; end
    if (kill_out) inc++;
    ncnt = (mcnt + inc > CNT_MAX) ? CNT_MAX : mcnt + inc;
    if (miss_req)  begin nv[0] = 1; npc[0] = miss_pc; end
    if (e_exc_ack) begin nv[1] = 1; npc[1] = exc_pc;  end
    if (e_bb_ack)  begin nv[3] = 1; npc[3] = bb_pc;   end
    nov = ov; nopc = opc; nosrc = osrc;
    if (may_load) begin
      nov = (pick >= 0);
      if (pick >= 0) begin
        nosrc = pick;
        nopc  = (pick == 2) ? irq_pc : mpc[pick];
      end
    end
  endtask

  task automatic cycle();
    model_comb();
    @(posedge clk);
    mv = nv; mpc = npc; ov = nov; opc = nopc; osrc = nosrc; mcnt = ncnt;
    #1;
  endtask

  task automatic idle_inputs();
    miss_req = 0; exc_req = 0; irq_req = 0; bb_req = 0;
    irq_en = 0; micro_active = 0; redir_rdy = 1;
    miss_pc = '0; exc_pc = '0; irq_pc = '0; bb_pc = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({redir_v, redir_pc, redir_src, busy, cancel_cnt, bb_ack, exc_ack, irq_ack} !== '0) begin
      errors++;
      $display("FAIL reset_state: v=%0b pc=%h src=%0d busy=%0b cnt=%0d acks=%0b%0b%0b, required all 0",
               redir_v, redir_pc, redir_src, busy, cancel_cnt, bb_ack, exc_ack, irq_ack);
    end
  endtask

  task automatic test_miss_single();
    do_reset();
    miss_req = 1; miss_pc = 32'hFFFD0100;
    cycle();
    miss_req = 0;
    checks++;
    if (redir_v !== 1'b0) begin errors++; $display("FAIL miss_latency1: v=%0b required 0", redir_v); end
    cycle();
    checks++;
    if (redir_v !== 1'b1 || redir_pc !== 32'hFFFD0100 || redir_src !== 2'd0) begin
      errors++;
      $display("FAIL miss_emit: v=%0b pc=%h src=%0d required 1 fffd0100 0", redir_v, redir_pc, redir_src);
    end
    cycle();
    checks++;
    if (redir_v !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL miss_consumed: v=%0b busy=%0b required 0 0", redir_v, busy);
    end
  endtask

  task automatic test_bb_cancel();
    do_reset();
    bb_req = 1; bb_pc = 32'h1000;
    #1;
    checks++;
    if (bb_ack !== 1'b1) begin errors++; $display("FAIL bb_ack_first: ack=%0b required 1", bb_ack); end
    cycle();
    bb_req = 0; miss_req = 1; miss_pc = 32'h2000;
    cycle();
    miss_req = 0;
    checks++;
    if (cancel_cnt !== 4'd1 || redir_v !== 1'b0) begin
      errors++; $display("FAIL bb_cancelled: cnt=%0d v=%0b required 1 0", cancel_cnt, redir_v);
    end
    cycle();
    checks++;
    if (redir_v !== 1'b1 || redir_pc !== 32'h2000 || redir_src !== 2'd0) begin
      errors++; $display("FAIL miss_after_cancel: v=%0b pc=%h src=%0d required 1 2000 0", redir_v, redir_pc, redir_src);
    end
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (redir_v !== 1'b0) begin
        errors++; $display("FAIL bb_never_emitted: cycle %0d v=%0b pc=%h required v 0", i, redir_v, redir_pc);
      end
    end
  endtask

  task automatic test_exc_bb_hold();
    do_reset();
    redir_rdy = 0;
    exc_req = 1; exc_pc = 32'h3000; bb_req = 1; bb_pc = 32'h1000;
    #1;
    checks++;
    if (exc_ack !== 1'b1 || bb_ack !== 1'b1) begin
      errors++; $display("FAIL exc_bb_ack: exc_ack=%0b bb_ack=%0b required 1 1", exc_ack, bb_ack);
    end
    cycle();
    exc_req = 0; bb_req = 0;
    cycle();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (redir_v !== 1'b1 || redir_pc !== 32'h3000 || redir_src !== 2'd1) begin
        errors++; $display("FAIL exc_held: cycle %0d v=%0b pc=%h src=%0d required 1 3000 1", i, redir_v, redir_pc, redir_src);
      end
      cycle();
    end
    redir_rdy = 1;
    cycle();
    checks++;
    if (redir_v !== 1'b1 || redir_pc !== 32'h1000 || redir_src !== 2'd3) begin
      errors++; $display("FAIL bb_follows: v=%0b pc=%h src=%0d required 1 1000 3", redir_v, redir_pc, redir_src);
    end
    cycle();
    checks++;
    if (redir_v !== 1'b0) begin errors++; $display("FAIL bb_consumed: v=%0b required 0", redir_v); end
  endtask

  task automatic test_irq_micro();
    do_reset();
    irq_req = 1; irq_en = 1; micro_active = 1; irq_pc = 32'h5000;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (redir_v !== 1'b0 || irq_ack !== 1'b0) begin
        errors++; $display("FAIL irq_blocked: cycle %0d v=%0b irq_ack=%0b required 0 0", i, redir_v, irq_ack);
      end
    end
    micro_active = 0;
    cycle();
    checks++;
    if (redir_v !== 1'b1 || redir_pc !== 32'h5000 || redir_src !== 2'd2 || irq_ack !== 1'b1) begin
      errors++;
      $display("FAIL irq_emit: v=%0b pc=%h src=%0d irq_ack=%0b required 1 5000 2 1", redir_v, redir_pc, redir_src, irq_ack);
    end
    irq_req = 0;
    cycle();
    checks++;
    if (redir_v !== 1'b0 || irq_ack !== 1'b0) begin
      errors++; $display("FAIL irq_done: v=%0b irq_ack=%0b required 0 0", redir_v, irq_ack);
    end
  endtask

  task automatic test_miss_replace();
    do_reset();
    redir_rdy = 0;
    exc_req = 1; exc_pc = 32'h3000;
    cycle();
    exc_req = 0;
    cycle();
    miss_req = 1; miss_pc = 32'h4000;
    cycle();
    miss_req = 0;
    checks++;
    if (redir_pc !== 32'h3000 || redir_src !== 2'd1) begin
      errors++; $display("FAIL exc_before_replace: pc=%h src=%0d required 3000 1", redir_pc, redir_src);
    end
    cycle();
    checks++;
    if (redir_v !== 1'b1 || redir_pc !== 32'h4000 || redir_src !== 2'd0) begin
      errors++; $display("FAIL miss_replaces: v=%0b pc=%h src=%0d required 1 4000 0", redir_v, redir_pc, redir_src);
    end
    redir_rdy = 1;
    cycle();
    checks++;
    if (redir_v !== 1'b1 || redir_pc !== 32'h3000 || redir_src !== 2'd1) begin
      errors++; $display("FAIL exc_restored: v=%0b pc=%h src=%0d required 1 3000 1", redir_v, redir_pc, redir_src);
    end
    cycle();
    checks++;
    if (redir_v !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL replace_drained: v=%0b busy=%0b required 0 0", redir_v, busy);
    end
  endtask

  task automatic test_double_cancel_saturate();
    do_reset();
    redir_rdy = 0;
    bb_req = 1; bb_pc = 32'h1000;
    cycle();
    bb_pc = 32'h1100;
    #1;
    checks++;
    if (bb_ack !== 1'b1) begin errors++; $display("FAIL bb_ack_on_issue: ack=%0b required 1", bb_ack); end
    cycle();
    miss_req = 1; miss_pc = 32'h2000; bb_pc = 32'h1200;
    #1;
    checks++;
    if (bb_ack !== 1'b0) begin errors++; $display("FAIL bb_ack_with_miss: ack=%0b required 0", bb_ack); end
    cycle();
    miss_req = 0; bb_req = 0;
    checks++;
    if (cancel_cnt !== 4'd2 || redir_v !== 1'b0) begin
      errors++; $display("FAIL double_cancel: cnt=%0d v=%0b required 2 0", cancel_cnt, redir_v);
    end
    cycle();
    checks++;
    if (redir_v !== 1'b1 || redir_pc !== 32'h2000 || redir_src !== 2'd0) begin
      errors++; $display("FAIL miss_after_double: v=%0b pc=%h src=%0d required 1 2000 0", redir_v, redir_pc, redir_src);
    end
    redir_rdy = 1;
    for (int i = 0; i < 20; i++) begin
      exc_req = 1; exc_pc = $urandom; bb_req = 1; bb_pc = $urandom;
      cycle();
      checks++;
      if (cancel_cnt !== 4'(mcnt)) begin
        errors++; $display("FAIL cnt_track: cycle %0d cnt=%0d required %0d", i, cancel_cnt, mcnt);
      end
    end
    exc_req = 0; bb_req = 0;
    checks++;
    if (cancel_cnt !== 4'd15) begin errors++; $display("FAIL cnt_saturate: cnt=%0d required 15", cancel_cnt); end
  endtask

  task automatic test_async_reset();
    do_reset();
    redir_rdy = 0;
    exc_req = 1; exc_pc = 32'h3000; bb_req = 1; bb_pc = 32'h1000;
    cycle();
    exc_req = 0; bb_req = 0;
    cycle();
    exc_req = 1; exc_pc = 32'h3100;
    cycle();
    #2;
    rst = 1;
    #1;
    checks++;
    if ({redir_v, redir_pc, redir_src, busy, cancel_cnt, bb_ack, exc_ack, irq_ack} !== '0) begin
      errors++;
      $display("FAIL async_reset: v=%0b pc=%h src=%0d busy=%0b cnt=%0d exc_ack=%0b, required all 0",
               redir_v, redir_pc, redir_src, busy, cancel_cnt, exc_ack);
    end
    idle_inputs();
    @(negedge clk);
    rst = 0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (redir_v !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL no_replay: cycle %0d v=%0b busy=%0b required 0 0", i, redir_v, busy);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    irq_en = 1;
    for (int i = 0; i < 600; i++) begin
      miss_req = ($urandom_range(7) == 0);
      miss_pc  = $urandom;
      exc_req  = ($urandom_range(5) == 0);
      exc_pc   = $urandom;
      bb_req   = ($urandom_range(2) == 0);
      bb_pc    = $urandom;
      if ($urandom_range(9) == 0) irq_req = ~irq_req;
      irq_pc   = $urandom;
      if ($urandom_range(15) == 0) irq_en = ~irq_en;
      micro_active = ($urandom_range(3) == 0);
      redir_rdy    = ($urandom_range(2) != 0);
      #1;
      model_comb();
      checks++;
      if ({exc_ack, bb_ack, irq_ack} !== {e_exc_ack, e_bb_ack, e_irq_ack}) begin
        errors++;
        $display("FAIL rand_acks: cycle %0d exc/bb/irq=%0b%0b%0b required %0b%0b%0b",
                 i, exc_ack, bb_ack, irq_ack, e_exc_ack, e_bb_ack, e_irq_ack);
      end
      cycle();
      checks++;
      if (redir_v !== ov || busy !== (mv[0] | mv[1] | mv[3] | ov) || cancel_cnt !== 4'(mcnt) ||
          (ov && (redir_pc !== opc || redir_src !== 2'(osrc)))) begin
        errors++;
        $display("FAIL rand_out: cycle %0d v=%0b pc=%h src=%0d busy=%0b cnt=%0d required v=%0b pc=%h src=%0d busy=%0b cnt=%0d",
                 i, redir_v, redir_pc, redir_src, busy, cancel_cnt,
                 ov, opc, osrc, mv[0] | mv[1] | mv[3] | ov, mcnt);
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    model_reset();
    test_reset();
    test_miss_single();
    test_bb_cancel();
    test_exc_bb_hold();
    test_irq_micro();
    test_miss_replace();
    test_double_cancel_saturate();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
